// File: rtl/rcu_pipelined_pkg.sv
// Shared types for the 3-D mesh route computation unit.
// Holds the mesh geometry, coordinates, port numbering and the signed hop direction helper.
// No logic of its own; imported by the interface, the fault filter and the top.
package rcu_pipelined_pkg;

    localparam int MESH_WIDTH  = 4;
    localparam int MESH_HEIGHT = 4;
    localparam int MESH_DEPTH  = 4;
    localparam int COORD_W     = 2;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } position_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4,
        UP    = 3'd5,
        DOWN  = 3'd6
    } port_t;

    localparam int PORT_COUNT = 7;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } direction_t;

    // One extra bit on the difference so the borrow becomes the sign.
    function automatic direction_t hop_dir(input logic [COORD_W-1:0] dst,
                                           input logic [COORD_W-1:0] cur);
        logic [COORD_W:0] diff;
        diff = {1'b0, dst} - {1'b0, cur};
        if (diff == '0)
            return ZERO;
        else if (diff[COORD_W])
            return NEG;
        else
            return POS;
    endfunction

endpackage

// File: rtl/rcu_pipelined_if.sv
// Slot-level handshake bundle between input buffers / allocator and the route unit.
// Per-slot valid/ready for head flits, release from the allocator, held route outputs, raw fault status.
// RCU_STATS_EN adds stat_detour_cnt (16-bit saturating detour count).
interface rcu_pipelined_if #(parameter int N = 14);
    import rcu_pipelined_pkg::*;

    logic [N-1:0]      in_valid;
    position_t [N-1:0] in_dest;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      route_release;
    logic [N-1:0]      out_route_valid;
    port_t [N-1:0]     out_port;
    logic [N-1:0]      out_detour;
    logic              up_faulty_raw;
    logic              down_faulty_raw;
`ifdef RCU_STATS_EN
    logic [15:0]       stat_detour_cnt;
`endif

    modport master (
        output in_valid, in_dest, route_release, up_faulty_raw, down_faulty_raw,
`ifdef RCU_STATS_EN
        input  stat_detour_cnt,
`endif
        input  in_ready, out_route_valid, out_port, out_detour
    );

    modport slave (
        input  in_valid, in_dest, route_release, up_faulty_raw, down_faulty_raw,
`ifdef RCU_STATS_EN
        output stat_detour_cnt,
`endif
        output in_ready, out_route_valid, out_port, out_detour
    );

endinterface

// File: rtl/rcu_pipelined_fault_filter.sv
// Debounces one raw vertical-link fault status: 2-flop synchroniser then a saturating run counter.
// Latency: faulty rises FAULT_FILTER+2 cycles after raw rises, falls 3 cycles after raw falls.
// No backpressure; free-running.  Ports: clk, rst_n, raw (async in), faulty (registered-derived out).
module rcu_pipelined_fault_filter #(
    parameter int FAULT_FILTER = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic faulty
);
    localparam int CW = $clog2(FAULT_FILTER + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAULT_FILTER);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any single low sample restarts the run.
            if (!sync2)
                cnt <= '0;
            else if (cnt != LIMIT)
                cnt <= cnt + 1'b1;
        end
    end

    assign faulty = (cnt >= LIMIT);

endmodule

// File: rtl/rcu_pipelined.sv
// Registered Z-X-Y route computation for every (input port, VC) slot, with fault-aware vertical detours.
// Latency 1: route valid the cycle after accept; held until route_release, then one bubble before in_ready.
// Backpressure: in_ready[s] = ~busy[s], no combinational ready path.  Optional macro RCU_STATS_EN adds stat_detour_cnt.
// Ports: clk, rst_n (async active-low), rif (slave modport of rcu_pipelined_if).
module rcu_pipelined
    import rcu_pipelined_pkg::*;
#(
    parameter position_t   THIS_POS     = '{x: 0, y: 0, z: 0},
    parameter int          NUM_VC       = 2,
    parameter int          FAULT_FILTER = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    rcu_pipelined_if.slave rif
);
    localparam int N = PORT_COUNT * NUM_VC;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MESH_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MESH_HEIGHT - 1);

    logic          up_faulty;
    logic          down_faulty;
    logic [15:0]   lfsr;
    logic [N-1:0]  busy;
    logic [N-1:0]  acc;
    logic [N-1:0]  detour_q;
    logic [N-1:0]  nxt_detour;
    port_t [N-1:0] port_q;
    port_t [N-1:0] nxt_port;

    rcu_pipelined_fault_filter #(.FAULT_FILTER(FAULT_FILTER)) u_up_filter (
        .clk(clk), .rst_n(rst_n), .raw(rif.up_faulty_raw), .faulty(up_faulty)
    );

    rcu_pipelined_fault_filter #(.FAULT_FILTER(FAULT_FILTER)) u_down_filter (
        .clk(clk), .rst_n(rst_n), .raw(rif.down_faulty_raw), .faulty(down_faulty)
    );

    // Galois LFSR, polynomial 0xB400, free-running; supplies per-slot tie-break bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    for (genvar s = 0; s < N; s++) begin : g_slot
        localparam port_t INPORT = port_t'(s / NUM_VC);

        direction_t dz;
        direction_t dx;
        direction_t dy;
        port_t      xdir;
        logic       use_y;
        port_t      route_port;
        logic       route_det;

        always_comb begin
            dz         = hop_dir(rif.in_dest[s].z, THIS_POS.z);
            dx         = hop_dir(rif.in_dest[s].x, THIS_POS.x);
            dy         = hop_dir(rif.in_dest[s].y, THIS_POS.y);
            xdir       = EAST;
            use_y      = 1'b0;
            route_port = LOCAL;
            route_det  = 1'b0;
            if ((dz == POS && up_faulty) || (dz == NEG && down_faulty)) begin
                route_det = 1'b1;
                // Edge position or arrival side forces the X choice; otherwise the LFSR spreads load.
                if (THIS_POS.x == '0 || INPORT == WEST)
                    xdir = EAST;
                else if (THIS_POS.x == X_MAX || INPORT == EAST)
                    xdir = WEST;
                else
                    xdir = lfsr[s % 16] ? EAST : WEST;
                // No legal X hop (U-turn or off-mesh): side-step in Y instead.
                use_y = (MESH_WIDTH == 1) || (xdir == INPORT) ||
                        (xdir == EAST && THIS_POS.x == X_MAX) ||
                        (xdir == WEST && THIS_POS.x == '0);
                if (use_y)
                    route_port = (THIS_POS.y < Y_MAX) ? NORTH : SOUTH;
                else
                    route_port = xdir;
            end else if (dz == POS) begin
                route_port = UP;
            end else if (dz == NEG) begin
                route_port = DOWN;
            end else if (dx == POS) begin
                route_port = EAST;
            end else if (dx == NEG) begin
                route_port = WEST;
            end else if (dy == POS) begin
                route_port = NORTH;
            end else if (dy == NEG) begin
                route_port = SOUTH;
            end
        end

        assign nxt_port[s]   = route_port;
        assign nxt_detour[s] = route_det;
    end

    assign acc = rif.in_valid & ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            detour_q <= '0;
            for (int s = 0; s < N; s++)
                port_q[s] <= LOCAL;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (busy[s]) begin
                    if (rif.route_release[s])
                        busy[s] <= 1'b0;
                end else if (rif.in_valid[s]) begin
                    busy[s]     <= 1'b1;
                    port_q[s]   <= nxt_port[s];
                    detour_q[s] <= nxt_detour[s];
                end
            end
        end
    end

    assign rif.in_ready        = ~busy;
    assign rif.out_route_valid = busy;
    assign rif.out_port        = port_q;
    assign rif.out_detour      = detour_q;

`ifdef RCU_STATS_EN
    logic [15:0] stat_q;
    logic [16:0] stat_sum;

    always_comb begin
        stat_sum = {1'b0, stat_q};
        for (int s = 0; s < N; s++)
            stat_sum = stat_sum + {16'd0, acc[s] & nxt_detour[s]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_q <= '0;
        else
            stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end

    assign rif.stat_detour_cnt = stat_q;
`endif

endmodule

// File: tb/tb_rcu_pipelined.sv
module tb_rcu_pipelined;
    import rcu_pipelined_pkg::*;

    localparam int NUM_VC = 2;
    localparam int N      = PORT_COUNT * NUM_VC;
    localparam int FF     = 4;
    localparam position_t POS_A = '{x: 2'd1, y: 2'd1, z: 2'd1};
    localparam position_t POS_E = '{x: 2'd3, y: 2'd1, z: 2'd1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rcu_pipelined_if #(.N(N)) ifc ();
    rcu_pipelined_if #(.N(N)) ife ();

    rcu_pipelined #(.THIS_POS(POS_A), .NUM_VC(NUM_VC), .FAULT_FILTER(FF), .LFSR_SEED(16'hACE1))
        dut (.clk(clk), .rst_n(rst_n), .rif(ifc.slave));
    rcu_pipelined #(.THIS_POS(POS_E), .NUM_VC(NUM_VC), .FAULT_FILTER(FF), .LFSR_SEED(16'hACE1))
        dut_e (.clk(clk), .rst_n(rst_n), .rif(ife.slave));

    assign ife.up_faulty_raw   = ifc.up_faulty_raw;
    assign ife.down_faulty_raw = ifc.down_faulty_raw;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic position_t mk(input int x, input int y, input int z);
        position_t p;
        p.x = COORD_W'(x);
        p.y = COORD_W'(y);
        p.z = COORD_W'(z);
        return p;
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr = 16'hACE1;
    bit          m_busy [N];
    port_t       m_port [N];
    bit          m_det  [N];
    bit          up_hist[$];
    bit          dn_hist[$];
    int          m_stat = 0;

    // h[0] is the newest raw sample; a fault is visible once the samples
    // two to FF+1 edges old are all high (sync delay plus filter length).
    function automatic bit seen_fault(input bit h[$]);
        if (h.size() < FF + 2) return 1'b0;
        for (int k = 2; k < FF + 2; k++)
            if (!h[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void ref_route(input position_t here, input int slot, input position_t d,
                                      input bit upf, input bit dnf, input logic [15:0] rnd,
                                      output port_t p, output bit det);
        int dx, dy, dz;
        port_t inport;
        bit east;
        dx = int'(d.x) - int'(here.x);
        dy = int'(d.y) - int'(here.y);
        dz = int'(d.z) - int'(here.z);
        inport = port_t'(slot / NUM_VC);
        det = 1'b0;
        p = LOCAL;
        if ((dz > 0 && upf) || (dz < 0 && dnf)) begin
            det = 1'b1;
            if (here.x == 0 || inport == WEST) east = 1'b1;
            else if (int'(here.x) == MESH_WIDTH - 1 || inport == EAST) east = 1'b0;
            else east = rnd[slot % 16];
            if (MESH_WIDTH == 1 || (east ? inport == EAST : inport == WEST) ||
                (east && int'(here.x) == MESH_WIDTH - 1) || (!east && here.x == 0))
                p = (int'(here.y) < MESH_HEIGHT - 1) ? NORTH : SOUTH;
            else
                p = east ? EAST : WEST;
        end
        else if (dz > 0) p = UP;
        else if (dz < 0) p = DOWN;
        else if (dx > 0) p = EAST;
        else if (dx < 0) p = WEST;
        else if (dy > 0) p = NORTH;
        else if (dy < 0) p = SOUTH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit uf, df, d;
        port_t p;
        if (!rst_n) begin
            m_lfsr = 16'hACE1;
            for (int s = 0; s < N; s++) begin
                m_busy[s] = 1'b0;
                m_det[s]  = 1'b0;
                m_port[s] = LOCAL;
            end
            up_hist.delete();
            dn_hist.delete();
            m_stat = 0;
        end else begin
            uf = seen_fault(up_hist);
            df = seen_fault(dn_hist);
            for (int s = 0; s < N; s++) begin
                if (m_busy[s]) begin
                    if (ifc.route_release[s]) m_busy[s] = 1'b0;
                end else if (ifc.in_valid[s]) begin
                    ref_route(POS_A, s, ifc.in_dest[s], uf, df, m_lfsr, p, d);
                    m_busy[s] = 1'b1;
                    m_port[s] = p;
                    m_det[s]  = d;
                    if (d && m_stat < 16'hFFFF) m_stat++;
                end
            end
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            up_hist.push_front(ifc.up_faulty_raw);
            dn_hist.push_front(ifc.down_faulty_raw);
            if (up_hist.size() > FF + 2) void'(up_hist.pop_back());
            if (dn_hist.size() > FF + 2) void'(dn_hist.pop_back());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] ev, er;
        bit any_busy, route_ok;
        any_busy = 1'b0;
        route_ok = 1'b1;
        for (int s = 0; s < N; s++) begin
            ev[s] = m_busy[s];
            er[s] = !m_busy[s];
            if (m_busy[s]) begin
                any_busy = 1'b1;
                if (ifc.out_port[s] !== m_port[s] || ifc.out_detour[s] !== m_det[s]) begin
                    route_ok = 1'b0;
                    $display("FAIL route slot %0d: got port %0d det %0d want port %0d det %0d",
                             s, ifc.out_port[s], ifc.out_detour[s], m_port[s], m_det[s]);
                end
            end
        end
        check("cyc_valid", 64'(ifc.out_route_valid), 64'(ev));
        check("cyc_ready", 64'(ifc.in_ready), 64'(er));
        if (any_busy) begin
            total++;
            if (!route_ok) bad++;
        end
`ifdef RCU_STATS_EN
        check("cyc_stat", 64'(ifc.stat_detour_cnt), 64'(m_stat));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic offer(input int s, input position_t d);
        ifc.in_valid[s] = 1'b1;
        ifc.in_dest[s]  = d;
        @(negedge clk);
        ifc.in_valid[s] = 1'b0;
    endtask

    task automatic release_slot(input int s);
        ifc.route_release[s] = 1'b1;
        @(negedge clk);
        ifc.route_release[s] = 1'b0;
    endtask

    int seen_e, seen_w, stall;

    initial begin
        ifc.in_valid = '0;  ifc.route_release = '0;  ifc.in_dest = '0;
        ife.in_valid = '0;  ife.route_release = '0;  ife.in_dest = '0;
        ifc.up_faulty_raw = 1'b0;
        ifc.down_faulty_raw = 1'b0;
        seen_e = 0; seen_w = 0; stall = 0;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ifc.out_route_valid), 64'h0);
        check("rst_ready", 64'(ifc.in_ready), 64'h3FFF);
        check("rst_port", 64'(ifc.out_port), 64'h0);
        check("rst_detour", 64'(ifc.out_detour), 64'h0);
        offer(0, mk(2, 1, 1));              // dropped: still in reset
        check("rst_drop", 64'(ifc.out_route_valid[0]), 64'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("lfsr_step1", 64'(m_lfsr), 64'hE270);

        // 1: straight up, no faults
        offer(8, mk(1, 1, 3));
        check("t1_valid", 64'(ifc.out_route_valid[8]), 64'h1);
        check("t1_port", 64'(ifc.out_port[8]), 64'(UP));
        check("t1_det", 64'(ifc.out_detour[8]), 64'h0);
        release_slot(8);

        // 2: up fault settled -> EAST detour; at x=3 -> NORTH fallback
        ifc.up_faulty_raw = 1'b1;
        repeat (8) @(negedge clk);
        ife.in_valid[8] = 1'b1;
        ife.in_dest[8]  = mk(2, 1, 3);
        offer(8, mk(2, 1, 3));
        ife.in_valid[8] = 1'b0;
        check("t2_port", 64'(ifc.out_port[8]), 64'(EAST));
        check("t2_det", 64'(ifc.out_detour[8]), 64'h1);
        check("t2e_valid", 64'(ife.out_route_valid[8]), 64'h1);
        check("t2e_port", 64'(ife.out_port[8]), 64'(NORTH));
        check("t2e_det", 64'(ife.out_detour[8]), 64'h1);
        ife.route_release[8] = 1'b1;
        release_slot(8);
        ife.route_release[8] = 1'b0;
        ifc.up_faulty_raw = 1'b0;
        repeat (4) @(negedge clk);

        // 3: short glitch is filtered
        ifc.up_faulty_raw = 1'b1;
        repeat (3) @(negedge clk);
        ifc.up_faulty_raw = 1'b0;
        offer(8, mk(1, 1, 3));
        check("t3_port", 64'(ifc.out_port[8]), 64'(UP));
        check("t3_det", 64'(ifc.out_detour[8]), 64'h0);
        release_slot(8);

        // 4: persistent down fault, LFSR-chosen X detours from NORTH slots
        ifc.down_faulty_raw = 1'b1;
        repeat (FF + 3) @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            ifc.in_valid[2] = 1'b1;
            ifc.in_dest[2]  = mk(i % 4, (i / 4) % 4, 0);
            offer(3, mk((i + 1) % 4, (i / 2) % 4, 0));
            ifc.in_valid[2] = 1'b0;
            for (int s = 2; s < 4; s++) begin
                if (ifc.out_port[s] == EAST) seen_e++;
                if (ifc.out_port[s] == WEST) seen_w++;
            end
            ifc.route_release[2] = 1'b1;
            release_slot(3);
            ifc.route_release[2] = 1'b0;
        end
        check("t4_both", 64'({seen_e > 0, seen_w > 0}), 64'h3);
        check("t4_count", 64'(seen_e + seen_w), 64'd1000);
        ifc.down_faulty_raw = 1'b0;
        repeat (4) @(negedge clk);

        // 5: local delivery, release bubble, idle release
        offer(8, mk(1, 1, 1));
        check("t5_port", 64'(ifc.out_port[8]), 64'(LOCAL));
        ifc.route_release[8] = 1'b1;
        ifc.in_valid[8] = 1'b1;
        if (!ifc.in_ready[8]) stall++;
        @(negedge clk);
        ifc.route_release[8] = 1'b0;
        if (!ifc.in_ready[8]) stall++;
        @(negedge clk);
        ifc.in_valid[8] = 1'b0;
        check("t5_bubble", 64'(stall), 64'd1);
        check("t5_reaccept", 64'(ifc.out_route_valid[8]), 64'h1);
        release_slot(8);
        release_slot(9);
        check("t5_idle_rel_v", 64'(ifc.out_route_valid[9]), 64'h0);
        check("t5_idle_rel_r", 64'(ifc.in_ready[9]), 64'h1);

        // 6: every slot at once, then reset mid-hold
        for (int s = 0; s < N; s++) ifc.in_dest[s] = mk(s % 4, (s / 4) % 4, s % 3);
        ifc.in_valid = '1;
        @(negedge clk);
        ifc.in_valid = '0;
        check("t6_all", 64'(ifc.out_route_valid), 64'h3FFF);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(ifc.out_route_valid), 64'h0);
        check("t6_rst_port", 64'(ifc.out_port), 64'h0);
`ifdef RCU_STATS_EN
        check("t6_rst_stat", 64'(ifc.stat_detour_cnt), 64'h0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
